// File: rtl/data_pattern_gen_pkg.sv
// data_pattern_pkg
//   Shared definitions for the write-path test-data generator: pattern mode
//   codes, the controller state encoding, the PRBS-31 tap positions and a
//   helper that substitutes a legal seed when the LFSR would otherwise lock up.
package data_pattern_pkg;

    // Pattern selector values (mode input, 3 bits). Codes 5..7 give zero words.
    localparam logic [2:0] MODE_LANE_CNT = 3'd0;
    localparam logic [2:0] MODE_CNT      = 3'd1;
    localparam logic [2:0] MODE_WALK1    = 3'd2;
    localparam logic [2:0] MODE_PRBS31   = 3'd3;
    localparam logic [2:0] MODE_WALK0    = 3'd4;

    // Controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // PRBS-31 (x^31 + x^28 + 1) feedback taps within the 31-bit state.
    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;

    // An all-zero LFSR state never leaves zero, so replace it with all ones.
    function automatic logic [30:0] prbs31_seed(input logic [30:0] s);
        return (s == '0) ? '1 : s;
    endfunction

endpackage

// File: rtl/data_pattern_gen_prbs31_advance.sv
// prbs31_advance
//   Combinational PRBS-31 stepper. Advances a 31-bit Fibonacci LFSR by STEPS
//   positions in one cycle and returns every generated bit, first bit in the
//   MSB of bits_out.
//
// Ports:
//   state_in   in   31     current LFSR state
//   state_out  out  31     state after STEPS advances
//   bits_out   out  STEPS  generated bits, earliest at bit STEPS-1
module prbs31_advance
    import data_pattern_pkg::*;
#(
    parameter int STEPS = 32
) (
    input  logic [30:0]      state_in,
    output logic [30:0]      state_out,
    output logic [STEPS-1:0] bits_out
);

    always_comb begin
        logic [30:0] s;
        logic        nb;
        s        = state_in;
        nb       = 1'b0;
        bits_out = '0;
        for (int i = 0; i < STEPS; i++) begin
            nb                    = s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
            bits_out[STEPS-1-i]   = nb;
            s                     = {s[29:0], nb};
        end
        state_out = s;
    end

endmodule

// File: rtl/data_pattern_gen.sv
// data_pattern_gen
//   Burst test-data generator for the write path. On start it latches the
//   pattern mode, seed and burst length, then presents one word per accepted
//   valid/ready handshake until the burst ends (done pulse), is aborted, or
//   runs forever when burst_len is 0.
//
// Ports:
//   clk         in   1           rising-edge clock
//   reset       in   1           synchronous active-high reset
//   start       in   1           begin a burst (only honoured in IDLE)
//   abort       in   1           terminate a running burst, no done pulse
//   mode        in   3           pattern select (see data_pattern_pkg)
//   seed        in   DATA_WIDTH  first counter word / PRBS seed in [30:0]
//   burst_len   in   LEN_WIDTH   words per burst, 0 = continuous
//   data_out    out  DATA_WIDTH  current word
//   out_valid   out  1           data_out is valid
//   out_ready   in   1           consumer accepts when valid & ready
//   busy        out  1           burst in progress
//   done        out  1           one-cycle pulse after last accept
//   word_count  out  LEN_WIDTH   words accepted in current/last burst
module data_pattern_gen
    import data_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  word_count
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    state_t                state_q, state_d;
    logic [2:0]            mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [30:0]           lfsr_q, lfsr_d;
    logic                  done_q, done_d;

    logic [30:0]           prbs_in;
    logic [30:0]           prbs_next;
    logic [DATA_WIDTH-1:0] prbs_bits;
    logic                  accept;
    logic                  last_word;

    // ------------------------------------------------------------------
    // Pattern helpers
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] lane_init();
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w[i*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(i);
        return w;
    endfunction

    // Lanes advance independently; a lane overflow must not carry upward.
    function automatic logic [DATA_WIDTH-1:0] lane_step(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++)
            r[i*LANE_WIDTH +: LANE_WIDTH] = w[i*LANE_WIDTH +: LANE_WIDTH] + LANE_WIDTH'(NUM_LANES);
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] w);
        return {w[DATA_WIDTH-2:0], w[DATA_WIDTH-1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] first_word(
        input logic [2:0]            m,
        input logic [DATA_WIDTH-1:0] s,
        input logic [DATA_WIDTH-1:0] pb
    );
        case (m)
            MODE_LANE_CNT: return lane_init();
            MODE_CNT:      return s;
            MODE_WALK1:    return DATA_WIDTH'(1);
            MODE_PRBS31:   return pb;
            MODE_WALK0:    return ~DATA_WIDTH'(1);
            default:       return '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] next_word(
        input logic [2:0]            m,
        input logic [DATA_WIDTH-1:0] w,
        input logic [DATA_WIDTH-1:0] pb
    );
        case (m)
            MODE_LANE_CNT: return lane_step(w);
            MODE_CNT:      return w + DATA_WIDTH'(1);
            MODE_WALK1:    return rotl1(w);
            MODE_PRBS31:   return pb;
            MODE_WALK0:    return rotl1(w);
            default:       return '0;
        endcase
    endfunction

    // One stepper serves both the burst's first word (fresh seed) and every
    // following word (saved LFSR state).
    assign prbs_in = (state_q == ST_RUN) ? lfsr_q : prbs31_seed(seed[30:0]);

    prbs31_advance #(
        .STEPS (DATA_WIDTH)
    ) u_prbs (
        .state_in  (prbs_in),
        .state_out (prbs_next),
        .bits_out  (prbs_bits)
    );

    assign accept    = (state_q == ST_RUN) && out_ready;
    assign last_word = (len_q != '0) && (count_q == len_q - LEN_WIDTH'(1));

    // ------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        lfsr_d  = lfsr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    len_d   = burst_len;
                    count_d = '0;
                    data_d  = first_word(mode, seed, prbs_bits);
                    lfsr_d  = prbs_next;
                end
            end
            ST_RUN: begin
                // Abort wins over a simultaneous accept: that word is dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    count_d = count_q + LEN_WIDTH'(1);
                    if (last_word) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d = next_word(mode_q, data_q, prbs_bits);
                        lfsr_d = prbs_next;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            lfsr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
        end
    end

    assign data_out   = data_q;
    assign out_valid  = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_data_pattern_gen.sv
module tb_data_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [2:0]  mode;
    logic [31:0] seed;
    logic [15:0] burst_len;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;

    data_pattern_gen #(
        .DATA_WIDTH (32),
        .LANE_WIDTH (8),
        .LEN_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .seed       (seed),
        .burst_len  (burst_len),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference PRBS-31 word generator written from the polynomial:
    // b[n] = b[n-31] ^ b[n-28], history initialised from the seed.
    function automatic logic [31:0] prbs_ref(input logic [30:0] sd, input int idx);
        logic hist [0:31+64*32];
        logic [31:0] w;
        logic [30:0] s;
        s = (sd == '0) ? '1 : sd;
        for (int k = 0; k < 31; k++) hist[k] = s[30-k];
        for (int n = 31; n < 31 + (idx + 1) * 32; n++) hist[n] = hist[n-31] ^ hist[n-28];
        w = '0;
        for (int b = 0; b < 32; b++) w = {w[30:0], hist[31 + idx*32 + b]};
        return w;
    endfunction

    task automatic launch(input logic [2:0] m, input logic [31:0] sd, input logic [15:0] len);
        mode = m; seed = sd; burst_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; seed = '0;
        burst_len = '0; out_ready = 1'b0;
        tick(); tick();

        // Reset state, and reset overriding a start in the same cycle
        chk("rst_data",  data_out, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        chk("rst_done",  {31'b0, done}, 32'h0);
        chk("rst_wc",    {16'b0, word_count}, 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        chk("rst_over_start", {31'b0, out_valid}, 32'h0);
        reset = 1'b0; tick();

        // Mode 0, three words, ready held high
        out_ready = 1'b1;
        launch(3'd0, 32'h0, 16'd3);
        chk("m0_w0",    data_out, 32'h03020100);
        chk("m0_valid", {31'b0, out_valid}, 32'h1);
        chk("m0_busy",  {31'b0, busy}, 32'h1);
        chk("m0_wc0",   {16'b0, word_count}, 32'd0);
        tick();
        chk("m0_w1", data_out, 32'h07060504);
        chk("m0_nodone1", {31'b0, done}, 32'h0);
        tick();
        chk("m0_w2", data_out, 32'h0B0A0908);
        chk("m0_nodone2", {31'b0, done}, 32'h0);
        tick();
        chk("m0_done",   {31'b0, done}, 32'h1);
        chk("m0_vld0",   {31'b0, out_valid}, 32'h0);
        chk("m0_busy0",  {31'b0, busy}, 32'h0);
        chk("m0_wc3",    {16'b0, word_count}, 32'd3);
        chk("m0_hold",   data_out, 32'h0B0A0908);
        tick();
        chk("m0_done_1cyc", {31'b0, done}, 32'h0);
        chk("m0_wc_keep",   {16'b0, word_count}, 32'd3);

        // Mode 1 with wrap, ready toggling 1,0,1,0,1
        out_ready = 1'b0;
        launch(3'd1, 32'hFFFFFFFE, 16'd3);
        chk("m1_w0", data_out, 32'hFFFFFFFE);
        out_ready = 1'b1; tick();
        chk("m1_w1", data_out, 32'hFFFFFFFF);
        chk("m1_wc1", {16'b0, word_count}, 32'd1);
        out_ready = 1'b0; tick();
        chk("m1_stall_data", data_out, 32'hFFFFFFFF);
        chk("m1_stall_wc", {16'b0, word_count}, 32'd1);
        out_ready = 1'b1; tick();
        chk("m1_w2_wrap", data_out, 32'h00000000);
        out_ready = 1'b0; tick();
        chk("m1_stall2_data", data_out, 32'h00000000);
        chk("m1_stall2_wc", {16'b0, word_count}, 32'd2);
        chk("m1_stall2_vld", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1; tick();
        chk("m1_done", {31'b0, done}, 32'h1);
        chk("m1_wc3", {16'b0, word_count}, 32'd3);
        tick();

        // Mode 3 PRBS-31, one-word burst
        out_ready = 1'b0;
        launch(3'd3, 32'h7FFFFFFF, 16'd1);
        chk("m3_w0", data_out, 32'h0000000E);
        out_ready = 1'b1; tick();
        chk("m3_done", {31'b0, done}, 32'h1);
        chk("m3_wc1", {16'b0, word_count}, 32'd1);
        tick();

        // Mode 3, two words: second word hand value and reference model
        out_ready = 1'b0;
        launch(3'd3, 32'h7FFFFFFF, 16'd2);
        out_ready = 1'b1; tick();
        chk("m3_w1_hand",  data_out, 32'h000000FC);
        chk("m3_w1_model", data_out, prbs_ref(31'h7FFFFFFF, 1));
        tick();
        chk("m3b_done", {31'b0, done}, 32'h1);

        // Mode 3 with zero seed bits falls back to all ones
        out_ready = 1'b0;
        launch(3'd3, 32'h80000000, 16'd4);
        chk("m3_zero_seed", data_out, 32'h0000000E);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("m3_abort_vld", {31'b0, out_valid}, 32'h0);

        // Mode 2 continuous, 33 accepts, then abort racing an accept
        out_ready = 1'b1;
        launch(3'd2, 32'h0, 16'd0);
        chk("m2_w0", data_out, 32'h1);
        for (int k = 1; k <= 32; k++) begin
            tick();
            e = 32'h1 << (k % 32);
            chk("m2_walk", data_out, e);
            chk("m2_nodone", {31'b0, done}, 32'h0);
        end
        tick();
        chk("m2_w33", data_out, 32'h2);
        chk("m2_wc33", {16'b0, word_count}, 32'd33);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("m2_abort_vld",  {31'b0, out_valid}, 32'h0);
        chk("m2_abort_busy", {31'b0, busy}, 32'h0);
        chk("m2_abort_done", {31'b0, done}, 32'h0);
        chk("m2_abort_wc",   {16'b0, word_count}, 32'd33);
        chk("m2_abort_data", data_out, 32'h2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle_abort_vld", {31'b0, out_valid}, 32'h0);
        chk("idle_abort_wc",  {16'b0, word_count}, 32'd33);

        // Mode 6 zero words, start during RUN ignored
        out_ready = 1'b0;
        launch(3'd6, 32'h0, 16'd2);
        chk("m6_w0", data_out, 32'h0);
        chk("m6_vld", {31'b0, out_valid}, 32'h1);
        mode = 3'd1; seed = 32'h12345678; burst_len = 16'd5; start = 1'b1;
        out_ready = 1'b1; tick(); start = 1'b0;
        chk("m6_w1", data_out, 32'h0);
        chk("m6_wc1", {16'b0, word_count}, 32'd1);
        tick();
        chk("m6_done", {31'b0, done}, 32'h1);
        chk("m6_wc2", {16'b0, word_count}, 32'd2);
        chk("m6_vld0", {31'b0, out_valid}, 32'h0);
        tick();

        // Mode 0 continuous: 64 accepts wraps lanes; then reset mid-burst
        launch(3'd0, 32'h0, 16'd0);
        for (int k = 0; k < 63; k++) tick();
        chk("m0c_w63", data_out, 32'hFFFEFDFC);
        chk("m0c_wc63", {16'b0, word_count}, 32'd63);
        tick();
        chk("m0c_w64", data_out, 32'h03020100);
        chk("m0c_wc64", {16'b0, word_count}, 32'd64);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_vld",  {31'b0, out_valid}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_done", {31'b0, done}, 32'h0);
        chk("mid_rst_wc",   {16'b0, word_count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
